// File: rtl/aes_pkg.sv
// AES arithmetic helpers shared by the round datapath and the key schedule.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEXP,
    ST_KEY_OK,
    ST_RUN,
    ST_OUT
  } aes_state_e;

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, sq);
      sq = gmul(sq, sq);
    end
    return r;
  endfunction

  // S-boxes are computed (inverse + affine map) rather than tabulated.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned k = 0; k < 16; k++) o[127 - 8*k -: 8] = sbox(s[127 - 8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned k = 0; k < 16; k++) o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
    return o;
  endfunction

  // Byte 4c+r is row r of column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++) o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++) o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One AES round, combinational; encrypt or decrypt, with the final-round MixColumns bypass.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         inv,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] enc_mix;
  logic [127:0] dec_ark;

  // Forward path: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  // Inverse path: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  always_comb begin
    enc_mix = shift_rows(sub_bytes(state_in));
    if (!last) enc_mix = mix_columns(enc_mix);
    dec_ark = inv_sub_bytes(inv_shift_rows(state_in)) ^ rk;
    if (inv) state_out = last ? dec_ark : inv_mix_columns(dec_ark);
    else     state_out = enc_mix ^ rk;
  end

endmodule

// File: rtl/aes_core_iter.sv
// Iterative AES core: key schedule expanded once per key, then one round per clock per block.
module aes_core_iter
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         key_ok,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned NK  = KEY_BITS / 32;
  localparam int unsigned NR  = nr_of(KEY_BITS);
  localparam int unsigned NW  = 4 * (NR + 1);
  localparam int unsigned WIW = $clog2(NW);
  localparam int unsigned RW  = $clog2(NR + 1);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_core_iter: KEY_BITS must be 128, 192 or 256");
  end

  aes_state_e     state_q, state_d;
  logic           key_ok_q, key_ok_d;
  logic [127:0]   st_q, st_d;
  logic           inv_q, inv_d;
  logic [RW-1:0]  rnd_q, rnd_d;
  logic [WIW-1:0] kidx_q, kidx_d;
  logic [2:0]     kcol_q, kcol_d;
  logic [3:0]     rci_q, rci_d;
  logic [31:0]    w_q [NW];
  logic [31:0]    w_d [NW];

  logic           key_take;
  logic           in_take;
  logic           last_round;
  logic [RW-1:0]  rk_sel;
  logic [WIW-1:0] rk_base;
  logic [127:0]   rk;
  logic [127:0]   round_out;
  logic [31:0]    w_new;
  logic           unused_key_bits;

  // Only the top KEY_BITS of key_in carry key material.
  assign unused_key_bits = ^key_in;

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    key_ready = (state_q == ST_IDLE) || (state_q == ST_KEY_OK);
    in_ready  = (state_q == ST_KEY_OK) && !key_valid;
    out_valid = (state_q == ST_OUT);
    busy      = (state_q == ST_KEXP) || (state_q == ST_RUN) || (state_q == ST_OUT);
    key_ok    = key_ok_q;
    out_data  = out_valid ? st_q : '0;
    key_take  = key_valid && key_ready;
    in_take   = in_valid && in_ready;
  end

  // Round-key select: initial whitening key in KEY_OK, per-round key in RUN.
  always_comb begin
    if (state_q == ST_RUN) rk_sel = inv_q ? RW'(NR) - rnd_q : rnd_q;
    else                   rk_sel = in_inv ? RW'(NR) : '0;
    rk_base    = WIW'({rk_sel, 2'b00});
    rk         = {w_q[rk_base], w_q[rk_base + WIW'(1)],
                  w_q[rk_base + WIW'(2)], w_q[rk_base + WIW'(3)]};
    last_round = (rnd_q == RW'(NR));
  end

  aes_round u_round (
    .state_in  (st_q),
    .rk        (rk),
    .inv       (inv_q),
    .last      (last_round),
    .state_out (round_out)
  );

  // Next schedule word w[kidx]; kcol tracks kidx mod NK so no divider is needed.
  always_comb begin
    logic [31:0] t;
    t = w_q[kidx_q - WIW'(1)];
    if (kcol_q == '0)                      t = sub_word(rot_word(t)) ^ {rcon(rci_q), 24'h0};
    else if (NK == 8 && kcol_q == 3'd4)    t = sub_word(t);
    w_new = t ^ w_q[kidx_q - WIW'(NK)];
  end

  // Schedule array update: raw key words on a key handshake, one derived word per KEXP cycle.
  always_comb begin
    w_d = w_q;
    if (key_take) begin
      for (int unsigned j = 0; j < NK; j++) w_d[j] = key_in[255 - 32*j -: 32];
    end else if (state_q == ST_KEXP) begin
      w_d[kidx_q] = w_new;
    end
  end

  // Schedule storage; validity is tracked by key_ok_q so no reset is needed here.
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  // Next-state logic; a key handshake overrides everything else.
  always_comb begin
    state_d  = state_q;
    key_ok_d = key_ok_q;
    st_d     = st_q;
    inv_d    = inv_q;
    rnd_d    = rnd_q;
    kidx_d   = kidx_q;
    kcol_d   = kcol_q;
    rci_d    = rci_q;
    if (key_take) begin
      state_d  = ST_KEXP;
      key_ok_d = 1'b0;
      kidx_d   = WIW'(NK);
      kcol_d   = '0;
      rci_d    = 4'd1;
    end else begin
      case (state_q)
        ST_KEXP: begin
          kidx_d = kidx_q + WIW'(1);
          if (kcol_q == 3'(NK - 1)) begin
            kcol_d = '0;
            rci_d  = rci_q + 4'd1;
          end else begin
            kcol_d = kcol_q + 3'd1;
          end
          if (kidx_q == WIW'(NW - 1)) begin
            state_d  = ST_KEY_OK;
            key_ok_d = 1'b1;
          end
        end
        ST_KEY_OK: begin
          if (in_take) begin
            st_d    = in_data ^ rk;
            inv_d   = in_inv;
            rnd_d   = RW'(1);
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          st_d = round_out;
          if (last_round) state_d = ST_OUT;
          else            rnd_d   = rnd_q + RW'(1);
        end
        ST_OUT: begin
          if (out_ready) state_d = ST_KEY_OK;
        end
        default: ;
      endcase
    end
  end

  // Control and data-state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      key_ok_q <= 1'b0;
      st_q     <= '0;
      inv_q    <= 1'b0;
      rnd_q    <= '0;
      kidx_q   <= '0;
      kcol_q   <= '0;
      rci_q    <= '0;
    end else begin
      state_q  <= state_d;
      key_ok_q <= key_ok_d;
      st_q     <= st_d;
      inv_q    <= inv_d;
      rnd_q    <= rnd_d;
      kidx_q   <= kidx_d;
      kcol_q   <= kcol_d;
      rci_q    <= rci_d;
    end
  end

endmodule
